// File: rtl/arb_rr_8b_if.sv
// ---------------------------------------------------------------------------
// arb_rr_8b_if
//   Request/grant bundle between the requesters, the round-robin arbiter and
//   the downstream one-hot-to-binary encoder that consumes the grant.
//
//   Signals
//     req    N      request vector, bit k high = requester k wants service
//     ready  1      consumer accepts the current grant when ready && valid
//     valid  1      grant holds a valid one-hot grant
//     grant  N      registered one-hot grant, all-zero when valid = 0
//     ptr    log2N  current priority pointer (debug/visibility)
//
//   Modports
//     master  arbiter side: drives valid/grant/ptr, observes req/ready
//     slave   requester/consumer side: drives req/ready, observes the grant
// ---------------------------------------------------------------------------
interface arb_rr_8b_if #(
   parameter int N = 8
) ();
   logic [N-1:0]         req;
   logic                 ready;
   logic                 valid;
   logic [N-1:0]         grant;
   logic [$clog2(N)-1:0] ptr;

   modport master (
      input  req,
      input  ready,
      output valid,
      output grant,
      output ptr
   );

   modport slave (
      output req,
      output ready,
      input  valid,
      input  grant,
      input  ptr
   );
endinterface

// File: rtl/arb_rr_8b.sv
// ---------------------------------------------------------------------------
// arb_rr_8b
//   Round-robin arbiter for 8 requesters with a registered one-hot grant and
//   a valid/ready handshake. A grant is held unchanged while the consumer
//   applies backpressure and is only withdrawn by reset. After requester k is
//   served, requester k+1 (mod N) has the highest priority. With requests
//   pending, a transfer immediately loads the next grant, so one grant per
//   cycle is sustained.
//
//   Parameters
//     N         number of requesters; fixed at 8 to match the 3-bit encoder
//     PTR_INIT  priority pointer value after reset (0..N-1)
//
//   Ports
//     clk_i     clock, all state updates on the rising edge
//     rst_i     synchronous active-high reset, dominates every other event
//     bus       arb_rr_8b_if master modport (req, ready in; valid, grant, ptr out)
// ---------------------------------------------------------------------------
module arb_rr_8b #(
   parameter int N        = 8,
   parameter int PTR_INIT = 0
) (
   input  logic           clk_i,
   input  logic           rst_i,
   arb_rr_8b_if.master    bus
);
   localparam int PW = $clog2(N);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state_reg;
   logic [N-1:0]    grant_reg;
   logic            valid_reg;
   logic [PW-1:0]   ptr_reg;

   logic [PW-1:0]   grant_idx;
   logic [PW-1:0]   ptr_next;
   logic [N-1:0]    pick_idle;
   logic [N-1:0]    pick_xfer;

   // First set bit of req scanning upward from bit ptr with wrap-around.
   // The doubled vector turns the circular scan into a plain right shift;
   // x & -x isolates the lowest set bit, and the doubled left shift rotates
   // that bit back to its original position.
   function automatic logic [N-1:0] pick(
      input logic [N-1:0]  req,
      input logic [PW-1:0] ptr
   );
      logic [2*N-1:0] dbl;
      logic [N-1:0]   rot;
      logic [N-1:0]   first;
      logic [2*N-1:0] back;
      dbl   = {req, req} >> ptr;
      rot   = dbl[N-1:0];
      first = rot & (~rot + N'(1));
      back  = {first, first} << ptr;
      return back[2*N-1:N];
   endfunction

   // One-hot to index of the current grant: index bit gi is the OR of every
   // grant bit whose position has bit gi set.
   genvar gi, gj;
   generate
      for (gi = 0; gi < PW; gi++) begin : g_enc
         logic [N-1:0] sel;
         for (gj = 0; gj < N; gj++) begin : g_bit
            if (((gj >> gi) & 1) != 0) begin : g_on
               assign sel[gj] = grant_reg[gj];
            end else begin : g_off
               assign sel[gj] = 1'b0;
            end
         end
         assign grant_idx[gi] = |sel;
      end
   endgenerate

   // Priority moves to the requester just after the one being served.
   assign ptr_next  = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;

   assign pick_idle = pick(bus.req, ptr_reg);
   assign pick_xfer = pick(bus.req, ptr_next);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         grant_reg <= '0;
         valid_reg <= 1'b0;
         ptr_reg   <= PW'(PTR_INIT);
      end else begin
         case (state_reg)
            IDLE: begin
               // ready has no effect here; only a request starts a grant.
               if (|bus.req) begin
                  grant_reg <= pick_idle;
                  valid_reg <= 1'b1;
                  state_reg <= GRANT;
               end else begin
                  grant_reg <= '0;
                  valid_reg <= 1'b0;
               end
            end
            GRANT: begin
               // Without ready everything holds, whatever req does.
               if (bus.ready) begin
                  ptr_reg <= ptr_next;
                  if (|bus.req) begin
                     grant_reg <= pick_xfer;
                  end else begin
                     grant_reg <= '0;
                     valid_reg <= 1'b0;
                     state_reg <= IDLE;
                  end
               end
            end
            default: begin
               grant_reg <= '0;
               valid_reg <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.valid = valid_reg;
   assign bus.grant = grant_reg;
   assign bus.ptr   = ptr_reg;

endmodule

// File: tb/tb_arb_rr_8b.sv
// ---------------------------------------------------------------------------
// tb_arb_rr_8b
//   Self-checking bench for arb_rr_8b: directed scenarios with literal
//   expectations, then randomized requests/backpressure/resets compared every
//   cycle against a behavioural round-robin model.
// ---------------------------------------------------------------------------
module tb_arb_rr_8b;
   localparam int N = 8;

   logic clk_i = 1'b0;
   logic rst_i;

   arb_rr_8b_if #(.N(N)) bus ();

   arb_rr_8b #(.N(N), .PTR_INIT(0)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   // Behavioural model: grant kept as an integer index, pointer as an integer.
   bit m_valid = 1'b0;
   int m_idx   = -1;
   int m_ptr   = 0;

   function automatic int rr_pick(input logic [N-1:0] req, input int from);
      for (int k = 0; k < N; k++) begin
         if (req[(from + k) % N]) return (from + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk_i) begin
      if (rst_i) begin
         m_valid = 1'b0;
         m_idx   = -1;
         m_ptr   = 0;
      end else if (!m_valid) begin
         if (bus.req != '0) begin
            m_idx   = rr_pick(bus.req, m_ptr);
            m_valid = 1'b1;
         end
      end else if (bus.ready) begin
         m_ptr = (m_idx + 1) % N;
         if (bus.req != '0) begin
            m_idx = rr_pick(bus.req, m_ptr);
         end else begin
            m_valid = 1'b0;
            m_idx   = -1;
         end
      end
   end

   // Per-cycle compare against the model plus invariants.
   logic [N-1:0] exp_grant;
   logic [2:0]   prev_ptr;
   bit           prev_xfer = 1'b0;
   bit           prev_rst  = 1'b1;
   bit           have_prev = 1'b0;

   always @(negedge clk_i) begin
      if (check_en) begin
         exp_grant = m_valid ? (N'(1) << m_idx) : '0;
         checks++;
         if (bus.valid !== m_valid || bus.grant !== exp_grant || bus.ptr !== 3'(m_ptr)) begin
            errors++;
            $display("FAIL model t=%0t: valid=%b grant=%h ptr=%0d, expected valid=%b grant=%h ptr=%0d",
                     $time, bus.valid, bus.grant, bus.ptr, m_valid, exp_grant, m_ptr);
         end
         checks++;
         assert (bus.valid ? $onehot(bus.grant) : (bus.grant == '0)) else begin
            errors++;
            $display("FAIL onehot t=%0t: valid=%b grant=%h", $time, bus.valid, bus.grant);
         end
         if (have_prev && !prev_xfer && !prev_rst) begin
            checks++;
            assert (bus.ptr == prev_ptr) else begin
               errors++;
               $display("FAIL ptr_stable t=%0t: ptr=%0d, expected %0d", $time, bus.ptr, prev_ptr);
            end
         end
         if (bus.valid && bus.ready && !rst_i)
            $display("xfer t=%0t grant=%h ptr=%0d", $time, bus.grant, bus.ptr);
         prev_ptr  = bus.ptr;
         prev_xfer = bus.valid && bus.ready;
         prev_rst  = rst_i;
         have_prev = 1'b1;
      end
   end

   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   task automatic chk(input string name, input logic v, input logic [7:0] g, input logic [2:0] p);
      checks++;
      if (bus.valid !== v || bus.grant !== g || bus.ptr !== p) begin
         errors++;
         $display("FAIL %s: got valid=%b grant=%h ptr=%0d, expected valid=%b grant=%h ptr=%0d",
                  name, bus.valid, bus.grant, bus.ptr, v, g, p);
      end
   endtask

   task automatic do_reset();
      bus.req   = '0;
      bus.ready = 1'b0;
      rst_i     = 1'b1;
      step();
      rst_i     = 1'b0;
   endtask

   logic [7:0] seq2 [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
   logic [7:0] req3 [5] = '{8'h04, 8'h80, 8'h00, 8'h00, 8'h00};

   initial begin
      rst_i     = 1'b1;
      bus.req   = '0;
      bus.ready = 1'b0;
      step();
      step();
      check_en = 1'b1;
      rst_i    = 1'b0;
      chk("reset_state", 1'b0, 8'h00, 3'd0);

      // 1: single request, single transfer
      bus.req = 8'h01; bus.ready = 1'b1;
      step();
      bus.req = 8'h00;
      chk("s1_grant", 1'b1, 8'h01, 3'd0);
      step();
      chk("s1_idle", 1'b0, 8'h00, 3'd1);

      // 2: all requesting, back-to-back rotation
      do_reset();
      bus.req = 8'hFF; bus.ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         chk($sformatf("s2_seq%0d", i), 1'b1, seq2[i], 3'(i));
      end

      // 3: backpressure holds grant 04 while req changes
      do_reset();
      bus.req = 8'h02;
      step();
      chk("s3_first", 1'b1, 8'h02, 3'd0);
      bus.ready = 1'b1; bus.req = 8'h04;
      step();
      bus.ready = 1'b0;
      chk("s3_grant", 1'b1, 8'h04, 3'd2);
      for (int i = 0; i < 5; i++) begin
         bus.req = req3[i];
         step();
         chk($sformatf("s3_hold%0d", i), 1'b1, 8'h04, 3'd2);
      end
      bus.ready = 1'b1;
      step();
      chk("s3_release", 1'b0, 8'h00, 3'd3);

      // 4: pointer wrap 7 -> 0
      bus.req = 8'h40;
      step();
      chk("s4_g40", 1'b1, 8'h40, 3'd3);
      bus.req = 8'h81;
      step();
      chk("s4_g80", 1'b1, 8'h80, 3'd7);
      step();
      chk("s4_g01", 1'b1, 8'h01, 3'd0);
      bus.req = 8'h00;
      step();
      chk("s4_idle", 1'b0, 8'h00, 3'd1);

      // 5: reset drops a grant in flight
      bus.req = 8'h10; bus.ready = 1'b0;
      step();
      chk("s5_g10", 1'b1, 8'h10, 3'd1);
      rst_i = 1'b1; bus.ready = 1'b1; bus.req = 8'hFF;
      step();
      chk("s5_reset", 1'b0, 8'h00, 3'd0);
      rst_i = 1'b0;
      step();
      chk("s5_g01", 1'b1, 8'h01, 3'd0);
      bus.req = 8'h00;
      step();
      chk("s5_idle", 1'b0, 8'h00, 3'd1);

      // 6: no requests, ready toggling
      for (int i = 0; i < 20; i++) begin
         bus.ready = (i % 2) != 0;
         step();
         chk($sformatf("s6_quiet%0d", i), 1'b0, 8'h00, 3'd1);
      end

      // Randomized phase, checked by the per-cycle compare process.
      for (int i = 0; i < 1500; i++) begin
         rst_i = ($urandom_range(0, 99) == 0);
         case ($urandom_range(0, 3))
            0:       bus.req = 8'h00;
            1:       bus.req = 8'h01 << $urandom_range(0, 7);
            2:       bus.req = 8'($urandom);
            default: bus.req = 8'($urandom) | 8'($urandom);
         endcase
         bus.ready = ($urandom_range(0, 3) != 0);
         step();
      end
      rst_i = 1'b0;
      bus.req = '0;
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
